// File: rtl/gxsim_qspi_pkg.sv
// Shared opcodes, chip-select codes, state encoding and helpers for the QSPI sequencer.
package gxsim_qspi_pkg;

    localparam logic [7:0] OP_READ_DEF  = 8'h0B;
    localparam logic [7:0] OP_WRITE_DEF = 8'h02;

    // chip_select is {bank_csn, host_csn}; exactly one active-low select is legal
    localparam logic [1:0] CS_HOST = 2'b10;
    localparam logic [1:0] CS_BANK = 2'b01;

    // SCK edges taken by opcode and address before the first data nybble
    localparam logic [9:0] HDR_EDGES = 10'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT
    } state_t;

    // Header fields captured from the SCK domain when a transaction starts
    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] address;
        logic [1:0]  chip_select;
        logic [9:0]  sck_counts;
    } hdr_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gxsim_qspi_sequencer_if.sv
// Register and SMEM back-end buses: master side is the sequencer, slave side the back-ends.
interface gxsim_qspi_sequencer_if #(
    parameter int unsigned SMEM_BW = 512
);
    localparam int unsigned SMEM_DW = SMEM_BW / 32;

    logic               reg_req;
    logic               reg_we;
    logic [31:0]        reg_addr;
    logic [31:0]        reg_wdata;
    logic [31:0]        reg_rdata;
    logic               reg_ack;

    logic               smem_req;
    logic               smem_we;
    logic [31:0]        smem_addr;
    logic [SMEM_BW-1:0] smem_wdata;
    logic [SMEM_DW-1:0] smem_wstrb;
    logic [SMEM_BW-1:0] smem_rdata;
    logic               smem_ack;

    modport master (
        output reg_req, reg_we, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack,
        output smem_req, smem_we, smem_addr, smem_wdata, smem_wstrb,
        input  smem_rdata, smem_ack
    );

    modport slave (
        input  reg_req, reg_we, reg_addr, reg_wdata,
        output reg_rdata, reg_ack,
        input  smem_req, smem_we, smem_addr, smem_wdata, smem_wstrb,
        output smem_rdata, smem_ack
    );

endinterface

// File: rtl/gxsim_edge_sync.sv
// Three-flop synchroniser with a rising-edge pulse taken between stages 2 and 3.
module gxsim_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse_c
);

    localparam int unsigned STAGES = 3;

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign pulse_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/gxsim_qspi_sequencer.sv
// Bridges QSPI slave notifications to register or SMEM back-end transactions.
module gxsim_qspi_sequencer
    import gxsim_qspi_pkg::*;
#(
    parameter int unsigned SMEM_BW  = 512,
    parameter logic [7:0]  OP_READ  = OP_READ_DEF,
    parameter logic [7:0]  OP_WRITE = OP_WRITE_DEF,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [9:0]         sck_counts,
    input  logic [7:0]         opcode,
    input  logic [31:0]        address,
    input  logic [1:0]         chip_select,
    input  logic [SMEM_BW-1:0] wdata,
    input  logic               notify_read,
    input  logic               notify_write,
    output logic [SMEM_BW-1:0] rdata,
    output logic               busy,
    output logic [15:0]        err_count,
    gxsim_qspi_sequencer_if.master bus
);

    localparam int unsigned SMEM_DW = SMEM_BW / 32;
    localparam int unsigned NW      = $clog2(SMEM_DW + 1);

    logic               rd_edge_c;
    logic               wr_edge_c;
    logic               pend_rd;
    logic               pend_wr;
    logic               take_rd_c;
    logic               take_wr_c;
    state_t             state;
    hdr_t               hdr;
    hdr_t               hdr_in_c;
    logic [SMEM_BW-1:0] wdata_q;
    logic [15:0]        tmo_cnt;
    int unsigned        raw_words_c;
    logic [NW-1:0]      words_c;
    logic [SMEM_DW-1:0] strb_c;
    logic               cs_ok_c;
    logic               to_reg_c;
    logic               ack_c;
    logic               tmo_hit_c;

    gxsim_edge_sync u_rd_sync (
        .clk     (clk),
        .rst_n   (resetn),
        .din     (notify_read),
        .pulse_c (rd_edge_c)
    );

    gxsim_edge_sync u_wr_sync (
        .clk     (clk),
        .rst_n   (resetn),
        .din     (notify_write),
        .pulse_c (wr_edge_c)
    );

    // IDLE takes a pending read before a pending write
    assign take_rd_c = (state == ST_IDLE) && pend_rd;
    assign take_wr_c = (state == ST_IDLE) && !pend_rd && pend_wr;

    // Hold notify edges until IDLE consumes them; repeated edges merge, a fresh edge beats the clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_rd <= 1'b0;
            pend_wr <= 1'b0;
        end else begin
            pend_rd <= (pend_rd && !take_rd_c) || rd_edge_c;
            pend_wr <= (pend_wr && !take_wr_c) || wr_edge_c;
        end
    end

    assign hdr_in_c  = {opcode, address, chip_select, sck_counts};
    assign cs_ok_c   = (hdr.chip_select == CS_HOST) || (hdr.chip_select == CS_BANK);
    assign to_reg_c  = (hdr.chip_select == CS_HOST);
    assign ack_c     = to_reg_c ? bus.reg_ack : bus.smem_ack;
    assign tmo_hit_c = (tmo_cnt == 16'(TIMEOUT - 1));

    // Words written: eight SCK edges per 32-bit word after the header, clamped to the burst.
    // Counts short of the header are treated as an empty write rather than wrapping.
    always_comb begin
        raw_words_c = '0;
        words_c     = '0;
        if (hdr.sck_counts >= HDR_EDGES) begin
            raw_words_c = 32'((hdr.sck_counts - HDR_EDGES) >> 3);
            words_c     = (raw_words_c > SMEM_DW) ? NW'(SMEM_DW) : NW'(raw_words_c);
        end
    end

    // Word 0 sits at the top of the burst, so the enables fill from the MSB down
    assign strb_c = ~({SMEM_DW{1'b1}} >> words_c);

    // Transaction sequencer with registered bus, status and read-data outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            hdr            <= '0;
            wdata_q        <= '0;
            tmo_cnt        <= '0;
            rdata          <= '0;
            err_count      <= '0;
            bus.reg_req    <= 1'b0;
            bus.reg_we     <= 1'b0;
            bus.reg_addr   <= '0;
            bus.reg_wdata  <= '0;
            bus.smem_req   <= 1'b0;
            bus.smem_we    <= 1'b0;
            bus.smem_addr  <= '0;
            bus.smem_wdata <= '0;
            bus.smem_wstrb <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_rd_c || take_wr_c) begin
                        // SCK-domain buses are quiet from the notify edge until the next CS
                        hdr     <= hdr_in_c;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        state   <= take_rd_c ? ST_RD_REQ : ST_WR_REQ;
                    end
                end

                ST_RD_REQ: begin
                    tmo_cnt <= '0;
                    if (hdr.opcode != OP_READ) begin
                        // Not a read; the write notify will deal with it
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (!cs_ok_c) begin
                        err_count <= sat_inc16(err_count);
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        state <= ST_RD_WAIT;
                        if (to_reg_c) begin
                            bus.reg_req  <= 1'b1;
                            bus.reg_we   <= 1'b0;
                            bus.reg_addr <= hdr.address;
                        end else begin
                            bus.smem_req  <= 1'b1;
                            bus.smem_we   <= 1'b0;
                            bus.smem_addr <= hdr.address;
                        end
                    end
                end

                ST_WR_REQ: begin
                    tmo_cnt <= '0;
                    if (hdr.opcode != OP_WRITE) begin
                        // Reads also raise the write notify at CS release; only unknown opcodes are errors
                        if (hdr.opcode != OP_READ) begin
                            err_count <= sat_inc16(err_count);
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (!cs_ok_c) begin
                        err_count <= sat_inc16(err_count);
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end else if (words_c == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_WR_WAIT;
                        if (to_reg_c) begin
                            bus.reg_req   <= 1'b1;
                            bus.reg_we    <= 1'b1;
                            bus.reg_addr  <= hdr.address;
                            bus.reg_wdata <= wdata_q[SMEM_BW-1 -: 32];
                        end else begin
                            bus.smem_req   <= 1'b1;
                            bus.smem_we    <= 1'b1;
                            bus.smem_addr  <= hdr.address;
                            bus.smem_wdata <= wdata_q;
                            bus.smem_wstrb <= strb_c;
                        end
                    end
                end

                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (ack_c || tmo_hit_c) begin
                        bus.reg_req  <= 1'b0;
                        bus.smem_req <= 1'b0;
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                        if (ack_c) begin
                            if (state == ST_RD_WAIT) begin
                                rdata <= to_reg_c ? {bus.reg_rdata, {(SMEM_BW-32){1'b0}}}
                                                  : bus.smem_rdata;
                            end
                        end else begin
                            err_count <= sat_inc16(err_count);
                            if (state == ST_RD_WAIT) begin
                                rdata <= '0;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gxsim_qspi_sequencer.sv
// Scoreboard bench for gxsim_qspi_sequencer: directed scenarios plus randomized transactions.
module tb_gxsim_qspi_sequencer;

    localparam int unsigned BW = 512;

    typedef struct {
        bit          rd;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [1:0]  cs;
        logic [9:0]  cnt;
        logic [511:0] wdata;
    } txn_t;

    typedef struct {
        bit           is_reg;
        bit           we;
        logic [31:0]  addr;
        logic [31:0]  wd32;
        logic [511:0] wd;
        logic [15:0]  strb;
    } req_t;

    typedef struct {
        int           dly;
        logic [31:0]  r32;
        logic [511:0] r512;
    } resp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [9:0]    sck_counts;
    logic [7:0]    opcode;
    logic [31:0]   address;
    logic [1:0]    chip_select;
    logic [BW-1:0] wdata;
    logic          notify_read;
    logic          notify_write;
    logic [BW-1:0] rdata;
    logic          busy;
    logic [15:0]   err_count;

    gxsim_qspi_sequencer_if #(.SMEM_BW(BW)) bus ();

    gxsim_qspi_sequencer #(.SMEM_BW(BW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sck_counts   (sck_counts),
        .opcode       (opcode),
        .address      (address),
        .chip_select  (chip_select),
        .wdata        (wdata),
        .notify_read  (notify_read),
        .notify_write (notify_write),
        .rdata        (rdata),
        .busy         (busy),
        .err_count    (err_count),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int     n_pass = 0;
    int     n_total = 0;
    int     exp_err = 0;
    req_t   exp_req_q[$];
    logic [511:0] exp_rd_q[$];
    resp_t  resp_q[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic txn_t mk(input bit rd, input logic [7:0] op, input logic [31:0] addr,
                                input logic [1:0] cs, input logic [9:0] cnt, input logic [511:0] wd);
        txn_t t;
        t.rd = rd; t.op = op; t.addr = addr; t.cs = cs; t.cnt = cnt; t.wdata = wd;
        return t;
    endfunction

    // Reference model: what one notify should produce on the back-end buses, in rdata and in err_count
    function automatic void model(input txn_t t, input logic [31:0] r32, input logic [511:0] r512,
                                  input int dly, output bit has_req, output req_t rq,
                                  output bit has_rd, output logic [511:0] rd, output int err_inc);
        int  words;
        bit  cs_ok;
        cs_ok   = (t.cs == 2'b10) || (t.cs == 2'b01);
        has_req = 0; has_rd = 0; err_inc = 0; rd = '0;
        rq.is_reg = (t.cs == 2'b10); rq.we = 0; rq.addr = t.addr;
        rq.wd32 = '0; rq.wd = '0; rq.strb = '0;
        words = (t.cnt < 16) ? 0 : (int'(t.cnt) - 16) / 8;
        if (words > 16) words = 16;
        if (t.rd) begin
            if (t.op != 8'h0B) return;
            if (!cs_ok) begin err_inc = 1; return; end
            has_req = 1;
            has_rd  = 1;
            if (dly < 0) rd = '0;
            else if (rq.is_reg) rd = {r32, 480'b0};
            else rd = r512;
        end else begin
            if (t.op == 8'h0B) return;
            if (t.op != 8'h02 || !cs_ok) begin err_inc = 1; return; end
            if (words == 0) return;
            has_req = 1;
            rq.we   = 1;
            rq.wd32 = t.wdata[511:480];
            rq.wd   = t.wdata;
            for (int i = 0; i < 16; i++) rq.strb[15-i] = (i < words);
        end
        if (dly < 0) err_inc = 1;
    endfunction

    task automatic apply(input txn_t t);
        sck_counts  = t.cnt;
        opcode      = t.op;
        address     = t.addr;
        chip_select = t.cs;
        wdata       = t.wdata;
    endtask

    task automatic expect_txn(input txn_t t, input logic [31:0] r32, input logic [511:0] r512,
                              input int dly);
        bit hr, hd; req_t rq; logic [511:0] rd; int ei; resp_t rs;
        model(t, r32, r512, dly, hr, rq, hd, rd, ei);
        if (hr) begin
            exp_req_q.push_back(rq);
            rs.dly = dly; rs.r32 = r32; rs.r512 = r512;
            resp_q.push_back(rs);
        end
        if (hd) exp_rd_q.push_back(rd);
        exp_err = (exp_err + ei > 65535) ? 65535 : exp_err + ei;
    endtask

    task automatic wait_idle(input string name);
        int zeros; int n;
        zeros = 0; n = 0;
        while (zeros < 2 && n < 1500) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) zeros++; else zeros = 0;
        end
        if (zeros < 2) begin
            n_total++;
            $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!(bus.reg_req === 1'b1 || bus.smem_req === 1'b1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            n_total++;
            $display("FAIL %s: no bus request after %0d cycles, required one", name, n);
        end
    endtask

    task automatic run_txn(input string name, input txn_t t, input logic [31:0] r32,
                           input logic [511:0] r512, input int dly);
        apply(t);
        expect_txn(t, r32, r512, dly);
        @(posedge clk); #1;
        if (t.rd) notify_read = 1'b1; else notify_write = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        notify_read = 1'b0; notify_write = 1'b0;
        wait_idle(name);
        chk({name, "_err_count"}, err_count, exp_err);
    endtask

    // Back-end responder: acks each request after its scheduled delay (negative = never)
    initial begin : responder
        resp_t e; bit active; bit ack_on; bit cur_reg; int cd; logic req;
        active = 0; ack_on = 0; cur_reg = 0; cd = 0;
        e.dly = 0; e.r32 = '0; e.r512 = '0;
        bus.reg_ack = 1'b0; bus.smem_ack = 1'b0; bus.reg_rdata = '0; bus.smem_rdata = '0;
        forever begin
            @(negedge clk);
            req = (bus.reg_req === 1'b1) || (bus.smem_req === 1'b1);
            if (ack_on) begin
                bus.reg_ack = 1'b0; bus.smem_ack = 1'b0; ack_on = 0; active = 0;
            end else begin
                if (!active && req) begin
                    if (resp_q.size() > 0) e = resp_q.pop_front();
                    else begin e.dly = 0; e.r32 = '0; e.r512 = '0; end
                    active = 1; cd = e.dly; cur_reg = (bus.reg_req === 1'b1);
                end
                if (active && !req) active = 0;
                else if (active) begin
                    if (cd == 0) begin
                        if (cur_reg) begin bus.reg_rdata = e.r32; bus.reg_ack = 1'b1; end
                        else begin bus.smem_rdata = e.r512; bus.smem_ack = 1'b1; end
                        ack_on = 1;
                    end else if (cd > 0) cd--;
                end
            end
        end
    end

    // Monitor: checks each request as it rises and the read data as each read request falls
    initial begin : monitor
        req_t e; logic prev; logic cur; bit open_we;
        prev = 0; open_we = 1;
        forever begin
            @(negedge clk);
            cur = (bus.reg_req === 1'b1) || (bus.smem_req === 1'b1);
            if (!prev && cur) begin
                if (exp_req_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_req: reg_req=%0b smem_req=%0b, required none", bus.reg_req, bus.smem_req);
                    open_we = 1;
                end else begin
                    e = exp_req_q.pop_front();
                    open_we = e.we;
                    chk("req_target_reg", bus.reg_req, e.is_reg);
                    chk("req_target_smem", bus.smem_req, !e.is_reg);
                    if (e.is_reg) begin
                        chk("reg_we", bus.reg_we, e.we);
                        chk("reg_addr", bus.reg_addr, e.addr);
                        if (e.we) chk("reg_wdata", bus.reg_wdata, e.wd32);
                    end else begin
                        chk("smem_we", bus.smem_we, e.we);
                        chk("smem_addr", bus.smem_addr, e.addr);
                        if (e.we) begin
                            chk("smem_wdata", bus.smem_wdata, e.wd);
                            chk("smem_wstrb", bus.smem_wstrb, e.strb);
                        end
                    end
                end
            end
            if (prev && !cur && !open_we) begin
                if (exp_rd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_read_end: rdata=%h, no read outstanding", rdata);
                end else begin
                    chk("rdata", rdata, exp_rd_q.pop_front());
                end
            end
            prev = cur;
        end
    end

    initial begin : stim
        txn_t t; txn_t t2; logic [511:0] r; int sel;
        bit hr, hd; req_t rq; logic [511:0] rd; int ei;
        resetn = 1'b0; notify_read = 1'b0; notify_write = 1'b0;
        apply(mk(0, 8'h00, 32'h0, 2'b11, 10'd0, '0));
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_rdata", rdata, '0);
        chk("reset_reg_req", bus.reg_req, 1'b0);
        chk("reset_smem_req", bus.smem_req, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err_count", err_count, 16'd0);

        // Reset pulsed while a host read waits for its ack
        t = mk(1, 8'h0B, 32'h0000_2000, 2'b10, 10'd0, '0);
        apply(t);
        model(t, 32'h1234_5678, '0, -1, hr, rq, hd, rd, ei);
        exp_req_q.push_back(rq);
        exp_rd_q.push_back('0);
        resp_q.push_back('{100, 32'h1234_5678, 512'b0});
        @(posedge clk); #1 notify_read = 1'b1;
        repeat (6) @(posedge clk);
        #1 notify_read = 1'b0;
        wait_req("rst_mid_req");
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_reg_req", bus.reg_req, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rdata", rdata, '0);
        chk("rst_mid_err_count", err_count, 16'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Host read acked after 3 cycles
        run_txn("host_read", mk(1, 8'h0B, 32'h0000_1000, 2'b10, 10'd0, '0), 32'hCAFE_F00D, '0, 3);
        chk("host_read_top_word", rdata[511:480], 32'hCAFE_F00D);

        // Bank write of three words
        run_txn("bank_write", mk(0, 8'h02, 32'h0000_0400, 2'b01, 10'd40, rand512()), '0, '0, 1);

        // Host writes: below one word, then exactly one word
        run_txn("host_write_n0", mk(0, 8'h02, 32'h0000_0010, 2'b10, 10'd20, rand512()), '0, '0, 0);
        run_txn("host_write_n1", mk(0, 8'h02, 32'h0000_0014, 2'b10, 10'd24, rand512()), '0, '0, 2);

        // Read with no ack times out, next read proceeds normally
        run_txn("read_timeout", mk(1, 8'h0B, 32'h0000_3000, 2'b10, 10'd0, '0), 32'hDEAD_BEEF, '0, -1);
        run_txn("read_after_tmo", mk(1, 8'h0B, 32'h0000_3004, 2'b01, 10'd0, '0), '0, rand512(), 2);

        // Read and write notifies rise together: read first, write captured afterwards
        t = mk(1, 8'h0B, 32'h0000_5000, 2'b10, 10'd0, '0);
        apply(t);
        expect_txn(t, 32'h0BAD_F00D, '0, 4);
        @(posedge clk); #1 notify_read = 1'b1; notify_write = 1'b1;
        wait_req("both_read_req");
        t2 = mk(0, 8'h02, 32'h0000_6000, 2'b01, 10'd56, rand512());
        apply(t2);
        expect_txn(t2, '0, '0, 1);
        repeat (2) @(posedge clk);
        #1 notify_read = 1'b0; notify_write = 1'b0;
        wait_req("both_write_req");
        wait_idle("both_idle");
        chk("both_err_count", err_count, exp_err);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            t.rd = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 9);
            t.op = (sel < 4) ? 8'h0B : (sel < 8) ? 8'h02 : 8'($urandom);
            t.addr = $urandom;
            t.cnt  = 10'($urandom_range(16, 200));
            t.wdata = rand512();
            if ($urandom_range(0, 4) == 0) begin
                t.cs = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                t.op = t.rd ? 8'h0B : 8'h02;
                if (t.cnt < 10'd24) t.cnt = 10'd24;
            end else begin
                t.cs = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            end
            r = rand512();
            run_txn("rand", t, $urandom, r, $urandom_range(0, 6));
        end

        chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        chk("rdata_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gxsim_qspi_sequencer.md
Name: gxsim_qspi_sequencer

Overview:
- Sits between the QSPI slave (SCK domain) and the system-clock register/SMEM back-ends.
- Synchronises the slave's notify_read/notify_write strobes and captures opcode, address, chip_select and wdata.
- Decodes each transaction and routes it to the register bus (host chip-select) or the SMEM bus (bank chip-select) with a req/ack handshake.
- Returns read data on rdata before the slave samples it.

Parameters:
- SMEM_BW, 512, bits per SMEM burst; must be a multiple of 32.
- OP_READ, 8'h0B, opcode that requests a read.
- OP_WRITE, 8'h02, opcode that requests a write.
- TIMEOUT, 1000, clk cycles to wait for ack before abandoning.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sck_counts  in  10  SCK edge count from the QSPI slave (async domain)
- opcode  in  8  decoded opcode (async)
- address  in  32  byte-swapped address (async)
- chip_select  in  2  {bank_csn, host_csn} latched at SCK 1 (async)
- wdata  in  SMEM_BW  write data; word 0 in the top 32 bits (async)
- notify_read  in  1  rising edge = header complete (async)
- notify_write  in  1  rising edge = CS released, write may be required (async)
- rdata  out  SMEM_BW  read data to the slave, MSB nybble first
- reg_req, reg_we  out  1  register bus request / write enable
- reg_addr  out  32
- reg_wdata  out  32
- reg_rdata  in  32
- reg_ack  in  1
- smem_req, smem_we  out  1  SMEM bus request / write enable
- smem_addr  out  32
- smem_wdata  out  SMEM_BW
- smem_wstrb  out  SMEM_BW/32  per-word enable; bit SMEM_DW-1-i enables word i
- smem_rdata  in  SMEM_BW
- smem_ack  in  1
- busy  out  1  state != IDLE
- err_count  out  16  saturating count of timeouts, bad chip-selects and bad opcodes

Behaviour:
- Reset values: all outputs 0; rdata 0; state IDLE; pend_rd and pend_wr flags 0. Asserting resetn mid-operation drops req immediately and discards the transaction.
- Synchronisation: notify_read and notify_write each pass through 3 flops. A rising edge between stages 2 and 3 sets pend_rd or pend_wr.
- Capture: async buses are sampled only in the cycle the sequencer leaves IDLE. Rationale: they were written at or before the notify edge and remain stable until the next CS assertion.
- Target select: chip_select == 2'b10 (host low) routes to REG; 2'b01 (bank low) routes to SMEM. 2'b00 or 2'b11: err_count++, no bus access, return to IDLE.
- States:
  - IDLE: if pend_rd, go to RD_REQ and clear pend_rd. Else if pend_wr, go to WR_REQ and clear pend_wr. pend_rd has priority when both are set.
  - RD_REQ: only if opcode == OP_READ, assert the selected req with we=0 and the address; go to RD_WAIT. Any other opcode goes to IDLE silently; it may be a write.
  - RD_WAIT: req held until ack.
    - REG ack: rdata = {reg_rdata, zeros}.
    - SMEM ack: rdata = smem_rdata.
    - In both cases deassert req in the same cycle and return to IDLE.
  - WR_REQ: only if opcode == OP_WRITE. Compute N = (sck_counts - 16) >> 3, clamped to SMEM_BW/32.
    - N == 0: go to IDLE silently.
    - REG: reg_wdata = wdata[SMEM_BW-1 -: 32]; words beyond 0 are ignored.
    - SMEM: smem_wdata = wdata; smem_wstrb has its top N bits set.
    - Go to WR_WAIT.
  - WR_WAIT: req held until ack, then return to IDLE.
  - Opcodes other than OP_READ/OP_WRITE on the write notify: err_count++.
- Timeout: a 16-bit counter runs in RD_WAIT/WR_WAIT. When it reaches TIMEOUT: deassert req, err_count++, rdata = 0 (reads only), return to IDLE.
- Latency: rdata is valid at most 4 (sync) + 1 + back-end latency clk cycles after the notify_read edge. The system integrator guarantees this is shorter than 14 SCK periods, the deadline for the slave's preload at SCK 30.
- A notify edge arriving while busy is held in its pend flag. A second edge of the same kind while the flag is still set is merged.
- err_count saturates at 16'hFFFF.

Decomposition:
- Package gxsim_qspi_pkg holds OP_READ/OP_WRITE defaults, the state encoding (IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT) and the chip-select codes.
- One sub-module, gxsim_edge_sync: 3-flop synchroniser plus rising-edge pulse, instanced twice.

Test Plan:
- Host read: chip_select=2'b10, opcode 0x0B, address 0x1000; reg_ack after 3 cycles with 0xCAFEF00D -> reg_addr=0x1000, reg_we=0, rdata top word 0xCAFEF00D, remainder 0, busy drops.
- Bank write: chip_select=2'b01, opcode 0x02, sck_counts=40, notify_write edge -> smem_we=1, smem_wstrb has its top 3 bits set, smem_wdata==wdata.
- Host write with sck_counts=20 -> N=0, no reg_req. With sck_counts=24 -> one reg write carrying the top word.
- No ack for TIMEOUT cycles on a read -> req drops, err_count=1, rdata=0, next read proceeds normally.
- notify_read and notify_write rise in the same cycle -> read serviced first, then write; no edge lost.
- resetn pulsed during RD_WAIT -> reg_req=0 immediately, rdata=0, state IDLE, err_count unchanged at 0.
